// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin share of one DFFRAM512x32 port between two requesters
// Bounded lock keeps ownership for RMW/bursts; read data returns one cycle after accept.
module ram_port_arbiter #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_W/8-1:0]   req0_we,
   input  logic [ADDR_W-1:0]     req0_addr,
   input  logic [DATA_W-1:0]     req0_wdata,
   input  logic                  req0_lock,
   output logic                  rsp0_valid,
   output logic [DATA_W-1:0]     rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_W/8-1:0]   req1_we,
   input  logic [ADDR_W-1:0]     req1_addr,
   input  logic [DATA_W-1:0]     req1_wdata,
   input  logic                  req1_lock,
   output logic                  rsp1_valid,
   output logic [DATA_W-1:0]     rsp1_rdata,
   output logic                  RAM_EN,
   output logic [DATA_W/8-1:0]   RAM_WE,
   output logic [ADDR_W-1:0]     RAM_A,
   output logic [DATA_W-1:0]     RAM_Di,
   input  logic [DATA_W-1:0]     RAM_Do
);
   localparam int BE_W = DATA_W / 8;
   localparam int LCW  = $clog2(MAX_LOCK + 1);

   typedef enum logic [1:0] {ARB = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   state_t           state, state_nx;
   logic             last_grant;
   logic [LCW-1:0]   lock_cnt, lock_cnt_nx, lock_inc;
   logic             rd_pend, rd_id;
   logic             gnt0, gnt1, acc, acc_lock;
   logic [BE_W-1:0]  acc_we;

   // Reset gates every grant so a simultaneous accept never reaches the RAM.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         case (state)
            OWN0:    gnt0 = req0_valid;
            OWN1:    gnt1 = req1_valid;
            default: begin
               if (req0_valid && (!req1_valid || last_grant))
                  gnt0 = 1'b1;
               else
                  gnt1 = req1_valid;
            end
         endcase
      end
   end

   assign acc        = gnt0 | gnt1;
   assign acc_we     = gnt1 ? req1_we : req0_we;
   assign acc_lock   = gnt1 ? req1_lock : req0_lock;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign lock_inc   = lock_cnt + LCW'(1);

   always_comb begin
      RAM_EN = acc;
      RAM_WE = '0;
      RAM_A  = '0;
      RAM_Di = '0;
      if (gnt0) begin
         RAM_WE = req0_we;
         RAM_A  = req0_addr;
         RAM_Di = req0_wdata;
      end else if (gnt1) begin
         RAM_WE = req1_we;
         RAM_A  = req1_addr;
         RAM_Di = req1_wdata;
      end
   end

   // The MAX_LOCK-th consecutive locked accept falls through to ARB.
   always_comb begin
      state_nx    = state;
      lock_cnt_nx = lock_cnt;
      if (acc) begin
         if (acc_lock && (int'(lock_inc) < MAX_LOCK)) begin
            state_nx    = gnt1 ? OWN1 : OWN0;
            lock_cnt_nx = lock_inc;
         end else begin
            state_nx    = ARB;
            lock_cnt_nx = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ARB;
         last_grant <= 1'b1;
         lock_cnt   <= '0;
         rd_pend    <= 1'b0;
         rd_id      <= 1'b0;
      end else begin
         state    <= state_nx;
         lock_cnt <= lock_cnt_nx;
         rd_pend  <= acc && (acc_we == '0);
         if (acc) begin
            last_grant <= gnt1;
            rd_id      <= gnt1;
         end
      end
   end

   assign rsp0_valid = rst_n && rd_pend && !rd_id;
   assign rsp1_valid = rst_n && rd_pend && rd_id;
   assign rsp0_rdata = rsp0_valid ? RAM_Do : '0;
   assign rsp1_rdata = rsp1_valid ? RAM_Do : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed and random checks of ram_port_arbiter against a transaction model
module tb_ram_port_arbiter;
   localparam int ADDR_W   = 9;
   localparam int DATA_W   = 32;
   localparam int MAX_LOCK = 4;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_lock, rsp0_valid;
   logic [3:0]  req0_we;
   logic [8:0]  req0_addr;
   logic [31:0] req0_wdata, rsp0_rdata;
   logic        req1_valid, req1_ready, req1_lock, rsp1_valid;
   logic [3:0]  req1_we;
   logic [8:0]  req1_addr;
   logic [31:0] req1_wdata, rsp1_rdata;
   logic        RAM_EN;
   logic [3:0]  RAM_WE;
   logic [8:0]  RAM_A;
   logic [31:0] RAM_Di, RAM_Do;

   logic        ram_clear;
   logic [31:0] ram_mem [512];

   int          n_err, n_chk;
   int          owner, run, last, pend_id, last_g;
   logic [31:0] pend_data;
   logic [31:0] ref_mem [512];

   ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_Di(RAM_Di), .RAM_Do(RAM_Do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural DFFRAM: byte-masked write, registered read.
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 512; i++) ram_mem[i] <= 32'h0;
      end else if (RAM_EN) begin
         for (int b = 0; b < 4; b++)
            if (RAM_WE[b]) ram_mem[RAM_A][8*b +: 8] <= RAM_Di[8*b +: 8];
         if (RAM_WE == 4'h0) RAM_Do <= ram_mem[RAM_A];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: predict the cycle from the model, compare, then advance the model.
   task automatic cycle();
      int          g;
      logic [3:0]  we;
      logic [8:0]  addr;
      logic [31:0] wd;
      logic        lk;
      #2;
      if (!rst_n)                       g = -1;
      else if (owner == 0)              g = req0_valid ? 0 : -1;
      else if (owner == 1)              g = req1_valid ? 1 : -1;
      else if (req0_valid && req1_valid) g = (last == 0) ? 1 : 0;
      else if (req0_valid)              g = 0;
      else if (req1_valid)              g = 1;
      else                              g = -1;
      we   = (g == 0) ? req0_we    : (g == 1) ? req1_we    : 4'h0;
      addr = (g == 0) ? req0_addr  : (g == 1) ? req1_addr  : 9'h0;
      wd   = (g == 0) ? req0_wdata : (g == 1) ? req1_wdata : 32'h0;
      lk   = (g == 1) ? req1_lock  : req0_lock;
      chk("req0_ready", 32'(req0_ready), 32'(g == 0));
      chk("req1_ready", 32'(req1_ready), 32'(g == 1));
      chk("ram_en", 32'(RAM_EN), 32'(g >= 0));
      chk("ram_we", 32'(RAM_WE), 32'(we));
      chk("ram_a", 32'(RAM_A), 32'(addr));
      chk("ram_di", RAM_Di, wd);
      chk("rsp0_valid", 32'(rsp0_valid), 32'(rst_n && pend_id == 0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(rst_n && pend_id == 1));
      chk("rsp0_rdata", rsp0_rdata, (rst_n && pend_id == 0) ? pend_data : 32'h0);
      chk("rsp1_rdata", rsp1_rdata, (rst_n && pend_id == 1) ? pend_data : 32'h0);
      last_g = g;
      @(posedge clk);
      if (!rst_n) begin
         owner = -1; run = 0; last = 1; pend_id = -1;
      end else begin
         pend_id = -1;
         if (g >= 0) begin
            last = g;
            if (lk && run + 1 < MAX_LOCK) begin
               owner = g; run = run + 1;
            end else begin
               owner = -1; run = 0;
            end
            if (we == 4'h0) begin
               pend_id = g; pend_data = ref_mem[addr];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (we[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0; req0_lock = 0;
      req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0; req1_lock = 0;
   endtask

   task automatic set0(input logic v, input logic [3:0] we, input logic [8:0] a,
                       input logic [31:0] d, input logic lk);
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_lock = lk;
   endtask

   task automatic set1(input logic v, input logic [3:0] we, input logic [8:0] a,
                       input logic [31:0] d, input logic lk);
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_lock = lk;
   endtask

   task automatic do_reset(input int n);
      idle();
      rst_n = 0;
      repeat (n) cycle();
      rst_n = 1;
   endtask

   initial begin
      n_err = 0; n_chk = 0;
      owner = -1; run = 0; last = 1; pend_id = -1; last_g = -1; pend_data = 0;
      for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
      ram_clear = 1;
      do_reset(3);
      ram_clear = 0;

      // Reset wins over a simultaneous request.
      rst_n = 0;
      set0(1, 4'hF, 9'd7, 32'hCAFEF00D, 0);
      set1(1, 4'h0, 9'd7, 32'h0, 0);
      #1 chk("rst_ram_en", 32'(RAM_EN), 32'h0);
      chk("rst_ram_di", RAM_Di, 32'h0);
      cycle();
      rst_n = 1;

      // Single write then read through the other requester.
      idle(); set0(1, 4'hF, 9'd5, 32'hDEADBEEF, 0);
      cycle();
      idle(); set1(1, 4'h0, 9'd5, 32'h0, 0);
      cycle();
      idle();
      #1 chk("single_rsp1_valid", 32'(rsp1_valid), 32'h1);
      chk("single_rsp1_rdata", rsp1_rdata, 32'hDEADBEEF);
      chk("single_rsp0_valid", 32'(rsp0_valid), 32'h0);
      cycle();

      // Contention from reset alternates 0,1,0,1.
      set0(1, 4'hF, 9'd1, 32'h01010101, 0); cycle();
      set0(1, 4'hF, 9'd2, 32'h02020202, 0); cycle();
      do_reset(2);
      set0(1, 4'h0, 9'd1, 32'h0, 0);
      set1(1, 4'h0, 9'd2, 32'h0, 0);
      for (int i = 0; i < 6; i++) begin
         #1 chk("alt_ready0", 32'(req0_ready), 32'(i % 2 == 0));
         chk("alt_ready1", 32'(req1_ready), 32'(i % 2 == 1));
         if (i > 0) chk("alt_rdata", rsp0_valid ? rsp0_rdata : rsp1_rdata,
                        (i % 2 == 1) ? 32'h01010101 : 32'h02020202);
         cycle();
      end

      // Partial byte write merges into existing word.
      idle(); set0(1, 4'hF, 9'd9, 32'h11223344, 0); cycle();
      idle(); set1(1, 4'b0010, 9'd9, 32'h0000AA00, 0); cycle();
      idle(); set1(1, 4'h0, 9'd9, 32'h0, 0); cycle();
      idle();
      #1 chk("byte_rdata", rsp1_rdata, 32'h1122AA44);
      cycle();

      // Lock bound: exactly MAX_LOCK consecutive accepts, then the other side.
      do_reset(1);
      set0(1, 4'h0, 9'd1, 32'h0, 1);
      set1(1, 4'h0, 9'd2, 32'h0, 0);
      for (int i = 0; i <= MAX_LOCK; i++) begin
         #1 chk("lock_ready0", 32'(req0_ready), 32'(i < MAX_LOCK));
         chk("lock_ready1", 32'(req1_ready), 32'(i == MAX_LOCK));
         cycle();
      end

      // Lock held across idle cycles with no timeout.
      idle(); set0(1, 4'h0, 9'd3, 32'h0, 1); cycle();
      set0(0, 4'h0, 9'd0, 32'h0, 0); set1(1, 4'h0, 9'd4, 32'h0, 0);
      repeat (3) begin
         #1 chk("hold_ready1", 32'(req1_ready), 32'h0);
         cycle();
      end
      set0(1, 4'h0, 9'd3, 32'h0, 0); cycle();
      cycle();

      // Reset right after a read accept drops the response.
      do_reset(1);
      set0(1, 4'h0, 9'd5, 32'h0, 0); cycle();
      idle(); rst_n = 0;
      #1 chk("midrst_rsp0", 32'(rsp0_valid), 32'h0);
      cycle();
      rst_n = 1;
      set0(1, 4'h0, 9'd1, 32'h0, 0);
      set1(1, 4'h0, 9'd2, 32'h0, 0);
      #1 chk("midrst_tie0", 32'(req0_ready), 32'h1);
      chk("midrst_rsp1", 32'(rsp1_valid), 32'h0);
      cycle();

      // Random traffic with holds, cancels and locks.
      idle();
      for (int n = 0; n < 600; n++) begin
         if (!req0_valid || last_g == 0)
            set0($urandom_range(3) != 0, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom),
                 9'($urandom_range(15)), $urandom, $urandom_range(2) == 0);
         else if ($urandom_range(9) == 0)
            req0_valid = 0;
         if (!req1_valid || last_g == 1)
            set1($urandom_range(3) != 0, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom),
                 9'($urandom_range(15)), $urandom, $urandom_range(2) == 0);
         else if ($urandom_range(9) == 0)
            req1_valid = 0;
         if ($urandom_range(199) == 0) rst_n = 0;
         cycle();
         rst_n = 1;
      end
      idle();
      cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
